// File: rtl/weight_load_sched.sv
// Step sequencer for weight_store_3: walks the enabled layers and their phases, and holds load
// until the store reports valid. It then hands each weight word to the engine over w_valid/w_ack.
module weight_load_sched #(
    parameter int PH_L0    = 8,
    parameter int PH_L1    = 8,
    parameter int PH_L2    = 8,
    parameter int PH_L3    = 8,
    parameter int PH_AFF   = 8,
    parameter int MASK_CYC = 2,
    parameter int TIMEOUT  = 15,
    parameter logic [3:0] CS_L0  = 4'd0,
    parameter logic [3:0] CS_L1  = 4'd1,
    parameter logic [3:0] CS_L2  = 4'd2,
    parameter logic [3:0] CS_L3  = 4'd3,
    parameter logic [3:0] CS_AFF = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] layer_mask,
    input  logic       st_valid,
    input  logic       w_ack,
    output logic       load,
    output logic [3:0] cs,
    output logic [2:0] phase,
    output logic       w_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [4:0] MASK_C  = MASK_CYC[4:0];
    localparam logic [4:0] TO_C    = TIMEOUT[4:0];
    localparam logic [2:0] LAST_L0 = 3'(PH_L0 - 1);
    localparam logic [2:0] LAST_L1 = 3'(PH_L1 - 1);
    localparam logic [2:0] LAST_L2 = 3'(PH_L2 - 1);
    localparam logic [2:0] LAST_L3 = 3'(PH_L3 - 1);
    localparam logic [2:0] LAST_AF = 3'(PH_AFF - 1);

    state_t     state_r, state_s;
    logic [2:0] lyr_r, lyr_s;
    logic [2:0] phase_r, phase_s;
    logic [4:0] cnt_r, cnt_s;
    logic [4:0] mask_r, mask_s;
    logic       err_r, err_s;
    logic [3:0] nxt_s;
    logic       load_r, w_valid_r, busy_r, done_r;
    logic [3:0] cs_r;

    // Lowest enabled layer index >= from; bit 3 flags that one exists.
    function automatic logic [3:0] next_layer(input logic [4:0] mask, input logic [2:0] from);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            res = (mask[i] && (3'(i) >= from)) ? {1'b1, 3'(i)} : res;
        end
        return res;
    endfunction

    function automatic logic [2:0] last_phase(input logic [2:0] idx);
        logic [2:0] res;
        case (idx)
            3'd0:    res = LAST_L0;
            3'd1:    res = LAST_L1;
            3'd2:    res = LAST_L2;
            3'd3:    res = LAST_L3;
            3'd4:    res = LAST_AF;
            default: res = 3'd0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] cs_code(input logic [2:0] idx);
        logic [3:0] res;
        case (idx)
            3'd0:    res = CS_L0;
            3'd1:    res = CS_L1;
            3'd2:    res = CS_L2;
            3'd3:    res = CS_L3;
            3'd4:    res = CS_AFF;
            default: res = CS_L0;
        endcase
        return res;
    endfunction

    // Next-state and step bookkeeping; abort overrides every state.
    always_comb begin
        state_s = state_r;
        lyr_s   = lyr_r;
        phase_s = phase_r;
        cnt_s   = cnt_r;
        mask_s  = mask_r;
        err_s   = err_r;
        nxt_s   = 4'd0;
        if (abort) begin
            state_s = S_IDLE;
            lyr_s   = 3'd0;
            phase_s = 3'd0;
            cnt_s   = 5'd0;
        end else begin
            case (state_r)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        mask_s  = layer_mask;
                        err_s   = 1'b0;
                        nxt_s   = next_layer(layer_mask, 3'd0);
                        phase_s = 3'd0;
                        cnt_s   = 5'd0;
                        if (nxt_s[3]) begin
                            lyr_s   = nxt_s[2:0];
                            state_s = S_LOAD;
                        end else begin
                            lyr_s   = 3'd0;
                            state_s = S_DONE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                S_LOAD: begin
                    // Early valids may be left over from the previous step, so they are ignored.
                    if (st_valid && (cnt_r >= MASK_C)) begin
                        state_s = S_HOLD;
                    end else if (cnt_r == TO_C) begin
                        state_s = S_ERR;
                        err_s   = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end
                S_HOLD: begin
                    if (w_ack) begin
                        state_s = S_GAP;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_GAP: begin
                    cnt_s = 5'd0;
                    if (phase_r != last_phase(lyr_r)) begin
                        phase_s = phase_r + 3'd1;
                        state_s = S_LOAD;
                    end else begin
                        nxt_s   = next_layer(mask_r, lyr_r + 3'd1);
                        phase_s = 3'd0;
                        if (nxt_s[3]) begin
                            lyr_s   = nxt_s[2:0];
                            state_s = S_LOAD;
                        end else begin
                            lyr_s   = 3'd0;
                            state_s = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State, step registers and outputs, all derived from the next state so outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            lyr_r     <= 3'd0;
            phase_r   <= 3'd0;
            cnt_r     <= 5'd0;
            mask_r    <= 5'd0;
            err_r     <= 1'b0;
            load_r    <= 1'b0;
            w_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cs_r      <= CS_L0;
        end else begin
            state_r   <= state_s;
            lyr_r     <= lyr_s;
            phase_r   <= phase_s;
            cnt_r     <= cnt_s;
            mask_r    <= mask_s;
            err_r     <= err_s;
            load_r    <= (state_s == S_LOAD) || (state_s == S_HOLD);
            w_valid_r <= (state_s == S_HOLD);
            busy_r    <= (state_s != S_IDLE) && (state_s != S_ERR);
            done_r    <= (state_s == S_DONE);
            cs_r      <= cs_code(lyr_s);
        end
    end

    assign load    = load_r;
    assign cs      = cs_r;
    assign phase   = phase_r;
    assign w_valid = w_valid_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_weight_load_sched.sv
// Randomised bench for weight_load_sched: store/engine models plus an expected step queue built
// from the layer mask and phase counts.
module tb_weight_load_sched;

    localparam int ACCEPT_MIN = 3;    // first LOAD cycle whose valid may be accepted
    localparam int TO_CYC     = 16;   // LOAD cycles before the timeout fires
    localparam int LAT_NOM    = 7;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, st_valid, eng_ack, ack_force, w_ack;
    logic [4:0] layer_mask;
    logic       load, w_valid, busy, done, err;
    logic [3:0] cs;
    logic [2:0] phase;

    assign w_ack = eng_ack | ack_force;

    always #5 clk = ~clk;

    weight_load_sched #(.PH_L1(3), .PH_AFF(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .layer_mask(layer_mask),
        .st_valid(st_valid), .w_ack(w_ack), .load(load), .cs(cs), .phase(phase),
        .w_valid(w_valid), .busy(busy), .done(done), .err(err)
    );

    int n_cmp = 0, n_mis = 0;
    int done_cnt = 0;
    int mode = 0;          // 0 nominal, 1 random latency, 2 stale valid, 3 never valid
    bit rnd_ack = 1'b0;
    int ack_fix = 1;
    int lc = 0, hc = 0, cur_lat = LAT_NOM, ackd = 0;
    bit pw = 1'b0, pd = 1'b0, perr = 1'b0, pgap = 1'b0, load_seen = 1'b0;
    logic [3:0] pcs;
    logic [2:0] pph;
    logic [6:0] expq[$];
    logic [6:0] logq[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ph_of(input int l);
        case (l)
            1:       return 3;
            4:       return 1;
            default: return 8;
        endcase
    endfunction

    // Expected (cs,phase) sequence: enabled layers in order, every phase of each.
    function automatic void build(input logic [4:0] m);
        expq.delete();
        for (int l = 0; l < 5; l++)
            if (m[l])
                for (int p = 0; p < ph_of(l); p++)
                    expq.push_back({4'(l), 3'(p)});
    endfunction

    function automatic int exp_accept();
        if (mode == 2) return ACCEPT_MIN;
        return (cur_lat < ACCEPT_MIN) ? ACCEPT_MIN : cur_lat;
    endfunction

    // Compare process, then store and engine models for the next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            lc = 0; hc = 0; pw = 1'b0; pd = 1'b0; perr = 1'b0; pgap = 1'b0;
            eng_ack = 1'b0; st_valid = 1'b0;
        end else begin
            load_seen = load_seen | load;
            if (done) done_cnt++;
            if (abort) begin
                chk("abort_load", load, 0);
                chk("abort_wvalid", w_valid, 0);
                chk("abort_done", done, 0);
                chk("abort_busy", busy, 0);
            end else begin
                if (pgap) begin
                    if (expq.size() > 0) chk("gap_then_load", {load, w_valid}, 2'b10);
                    else chk("gap_then_done", done, 1);
                end
                if (pw && w_ack) begin
                    chk("gap_load", load, 0);
                    chk("gap_wvalid", w_valid, 0);
                end
                if (w_valid && !pw) begin
                    if (expq.size() == 0) chk("unexpected_step", 1, 0);
                    else chk("step_cs_phase", {cs, phase}, expq.pop_front());
                    logq.push_back({cs, phase});
                    chk("accept_cycle", lc, exp_accept());
                    chk("hold_load", load, 1);
                    chk("hold_busy", busy, 1);
                end
                if (w_valid && pw)
                    chk("hold_stable", {cs, phase, load}, {pcs, pph, 1'b1});
                if (done) begin
                    chk("done_all_steps", expq.size(), 0);
                    chk("done_single", pd, 0);
                    chk("done_cs_phase", {cs, phase, load}, 8'd0);
                end
                if (err && !perr) begin
                    chk("err_after_timeout", lc, TO_CYC);
                    chk("err_load", load, 0);
                end
            end
            pgap = !abort && pw && w_ack;
            pw = w_valid; pd = done; perr = err; pcs = cs; pph = phase;
            if (!load) lc = 0;
            else if (!w_valid) begin
                lc++;
                if (lc == 1) cur_lat = (mode == 1) ? int'($urandom_range(1, 14)) : LAT_NOM;
            end
            st_valid = (mode == 2) ? 1'b1 : (mode == 3) ? 1'b0 : (load && lc >= cur_lat);
            if (w_valid) begin
                hc++;
                if (hc == 1) ackd = rnd_ack ? int'($urandom_range(0, 3)) : ack_fix;
            end else hc = 0;
            eng_ack = w_valid && (hc > ackd);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [4:0] m, input int budget, input bit poke, output int cyc);
        int d0;
        build(m);
        logq.delete();
        d0 = done_cnt;
        tick(); start = 1'b1; layer_mask = m;
        tick(); start = 1'b0; cyc = 1;
        if (poke) begin
            repeat (3) tick();
            start = 1'b1; layer_mask = ~m;
            tick(); start = 1'b0; cyc += 4;
        end
        while (done_cnt == d0 && cyc < budget) begin
            tick(); cyc++;
        end
        chk("seq_done", done_cnt - d0, 1);
        chk("seq_all_steps", expq.size(), 0);
        chk("seq_err", err, 0);
    endtask

    initial begin
        int cyc, d0;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; layer_mask = 5'd0; ack_force = 1'b0;
        eng_ack = 1'b0; st_valid = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_outputs", {load, cs, phase, w_valid, busy, done, err}, 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Full mask, nominal latency 7, ack one cycle after w_valid.
        run_seq(5'h1F, 1500, 1'b0, cyc);
        chk("n_steps_1f", logq.size(), 28);
        chk("step0_1f", logq[0], {4'd0, 3'd0});
        chk("step8_1f", logq[8], {4'd1, 3'd0});
        chk("step10_1f", logq[10], {4'd1, 3'd2});
        chk("step11_1f", logq[11], {4'd2, 3'd0});
        chk("step27_1f", logq[27], {4'd4, 3'd0});

        run_seq(5'b10010, 500, 1'b0, cyc);
        chk("n_steps_12", logq.size(), 4);
        chk("step0_12", logq[0], {4'd1, 3'd0});
        chk("step2_12", logq[2], {4'd1, 3'd2});
        chk("step3_12", logq[3], {4'd4, 3'd0});

        load_seen = 1'b0;
        run_seq(5'd0, 20, 1'b0, cyc);
        chk("mask0_latency_ok", cyc <= 2, 1);
        chk("mask0_no_load", load_seen, 0);

        mode = 2;
        run_seq(5'b00001, 500, 1'b0, cyc);
        mode = 1; rnd_ack = 1'b1;
        for (int i = 0; i < 6; i++) run_seq(5'($urandom_range(1, 31)), 1500, 1'b1, cyc);
        rnd_ack = 1'b0;

        // Store never answers: timeout, then start clears err and restarts.
        mode = 3;
        build(5'h1F);
        tick(); start = 1'b1; layer_mask = 5'h1F;
        tick(); start = 1'b0;
        cyc = 0;
        while (!err && cyc < 40) begin tick(); cyc++; end
        chk("err_raised", err, 1);
        chk("err_busy", busy, 0);
        mode = 0;
        run_seq(5'h01, 500, 1'b0, cyc);
        chk("restart_first", logq[0], {4'd0, 3'd0});

        // Abort while HOLD with w_ack in the same cycle.
        ack_fix = 5;
        build(5'h1F);
        tick(); start = 1'b1; layer_mask = 5'h1F;
        tick(); start = 1'b0;
        cyc = 0;
        while (!w_valid && cyc < 30) begin tick(); cyc++; end
        chk("abort_reached_hold", w_valid, 1);
        d0 = done_cnt;
        abort = 1'b1; ack_force = 1'b1;
        tick(); abort = 1'b0; ack_force = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", {busy, load}, 0);
        expq.delete();

        ack_fix = 20;
        run_seq(5'b10010, 500, 1'b0, cyc);
        ack_fix = 1;

        // Reset in the middle of a step.
        build(5'h1F);
        tick(); start = 1'b1; layer_mask = 5'h1F;
        tick(); start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {load, cs, phase, w_valid, busy, done, err}, 0);
        tick();
        rst_n = 1'b1;
        expq.delete();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
